// File: rtl/popcount_match_pipe.sv
// -----------------------------------------------------------------------------
// popcount_match_pipe
//
// Purpose:
//   Two-stage streaming detector. Each accepted WIDTH-bit word has its ones
//   counted. The count is compared against the ones digit (id % 10) of each of
//   NTARGETS 32-bit ID values that arrive alongside the word. The block reports
//   per-target hit flags, an OR'd match flag and the count itself. It also keeps
//   a saturating tally of the results that were consumed with a match.
//
//   Stage 1 registers the popcount and the ID digits. Stage 2 registers the
//   comparison results. All outputs come from stage 2 registers. Both stages
//   carry a valid bit and advance under a valid/ready handshake, so the block
//   sustains one word per cycle and never drops or duplicates a word.
//
// Parameters:
//   WIDTH     input word width in bits (>= 1)
//   NTARGETS  number of ID targets compared per word (>= 1)
//   CNT_W     width of the saturating match counter
//   OW        popcount width, $clog2(WIDTH+1)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   in_valid     in   input word valid
//   in_ready     out  block can accept a word this cycle
//   in_data      in   word to count
//   in_ids       in   unsigned IDs; target k = in_ids[32k +: 32]
//   out_valid    out  result valid
//   out_ready    in   consumer accepts result
//   out_ones     out  popcount of the word
//   out_hits     out  bit k set when ones == id_k % 10
//   out_match    out  OR of out_hits
//   clr_count    in   synchronous clear of match_count (wins over increment)
//   match_count  out  number of consumed results with out_match = 1
// -----------------------------------------------------------------------------
module popcount_match_pipe #(
  parameter  int WIDTH    = 9,
  parameter  int NTARGETS = 2,
  parameter  int CNT_W    = 16,
  localparam int OW       = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [32*NTARGETS-1:0] in_ids,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_ones,
  output logic [NTARGETS-1:0]   out_hits,
  output logic                  out_match,
  input  logic                  clr_count,
  output logic [CNT_W-1:0]      match_count
);

  // The compare width must hold both a popcount and a 4-bit digit. Because the
  // compare is done at this common width, a digit larger than WIDTH can never
  // equal a popcount. For a narrow WIDTH, that digit is not truncated into a
  // false hit.
  localparam int CW = (OW > 4) ? OW : 4;

  // Stage 1 state
  logic                       s1Valid_q, s1Valid_d;
  logic [OW-1:0]              s1Ones_q, s1Ones_d;
  logic [NTARGETS-1:0][3:0]   s1Digits_q, s1Digits_d;

  // Stage 2 state (drives the outputs)
  logic                       s2Valid_q, s2Valid_d;
  logic [OW-1:0]              s2Ones_q, s2Ones_d;
  logic [NTARGETS-1:0]        s2Hits_q, s2Hits_d;
  logic                       s2Match_q, s2Match_d;

  // Match tally
  logic [CNT_W-1:0]           count_q, count_d;

  // Handshake / flow control
  logic                       s2Adv;
  logic                       s1Adv;
  logic                       inFire;
  logic                       outFire;

  // Combinational results feeding the stage registers
  logic [OW-1:0]              inOnes;
  logic [NTARGETS-1:0][3:0]   inDigits;
  logic [NTARGETS-1:0]        s1Hits;

  // Stage 2 may load whenever it is empty or its result is being taken.
  // Stage 1 may load whenever it is empty or can hand its word to stage 2.
  // The stage 1 advance condition is also the input ready signal.
  assign s2Adv    = !s2Valid_q | out_ready;
  assign s1Adv    = !s1Valid_q | s2Adv;
  assign in_ready = s1Adv;
  assign inFire   = in_valid & in_ready;
  assign outFire  = s2Valid_q & out_ready;

  // Ones count of the incoming word and ones digit of every incoming ID.
  always_comb begin
    inOnes   = '0;
    inDigits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inOnes = inOnes + OW'(in_data[i]);
    end
    for (int k = 0; k < NTARGETS; k++) begin
      inDigits[k] = 4'(in_ids[32*k +: 32] % 32'd10);
    end
  end

  // Per-target compare of the stage 1 word against its own captured digits.
  always_comb begin
    s1Hits = '0;
    for (int k = 0; k < NTARGETS; k++) begin
      s1Hits[k] = (CW'(s1Ones_q) == CW'(s1Digits_q[k]));
    end
  end

  // Stage 1 next state. Data is only captured on an input handshake, so later
  // changes to in_ids cannot reach a word already in flight.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Ones_d   = s1Ones_q;
    s1Digits_d = s1Digits_q;
    if (s1Adv) begin
      s1Valid_d = inFire;
      if (inFire) begin
        s1Ones_d   = inOnes;
        s1Digits_d = inDigits;
      end
    end
  end

  // Stage 2 next state. While stalled, every field holds, so the outputs stay
  // stable until the consumer takes them.
  always_comb begin
    s2Valid_d = s2Valid_q;
    s2Ones_d  = s2Ones_q;
    s2Hits_d  = s2Hits_q;
    s2Match_d = s2Match_q;
    if (s2Adv) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Ones_d  = s1Ones_q;
        s2Hits_d  = s1Hits;
        s2Match_d = |s1Hits;
      end
    end
  end

  // Saturating tally of consumed matching results. A clear takes priority
  // over an increment in the same cycle.
  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (outFire && s2Match_q && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Stage registers and tally. Reset empties both stages, so any word in
  // flight is discarded without producing an output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Ones_q   <= '0;
      s1Digits_q <= '0;
      s2Valid_q  <= 1'b0;
      s2Ones_q   <= '0;
      s2Hits_q   <= '0;
      s2Match_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Ones_q   <= s1Ones_d;
      s1Digits_q <= s1Digits_d;
      s2Valid_q  <= s2Valid_d;
      s2Ones_q   <= s2Ones_d;
      s2Hits_q   <= s2Hits_d;
      s2Match_q  <= s2Match_d;
      count_q    <= count_d;
    end
  end

  assign out_valid   = s2Valid_q;
  assign out_ones    = s2Ones_q;
  assign out_hits    = s2Hits_q;
  assign out_match   = s2Match_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_popcount_match_pipe.sv
// -----------------------------------------------------------------------------
// tb_popcount_match_pipe
//
// Directed bench for popcount_match_pipe (WIDTH=9, NTARGETS=2).
// The bench uses two instances that share the same stimulus:
//   dut       CNT_W=16, the main result checks
//   dutSmall  CNT_W=2, the counter saturation checks
// The bench computes each expected result from the word and from the IDs that
// were driven at that word's input handshake.
// -----------------------------------------------------------------------------
module tb_popcount_match_pipe;

  localparam logic [63:0] IDS_A = {32'd123456783, 32'd985740900}; // digits t1=3, t0=0
  localparam logic [63:0] IDS_B = {32'd13, 32'd23};               // digits t1=3, t0=3

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic [63:0] in_ids;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ones;
  logic [1:0]  out_hits;
  logic        out_match;
  logic        clr_count;
  logic [15:0] match_count;

  logic        smInReady;
  logic        smOutValid;
  logic [3:0]  smOutOnes;
  logic [1:0]  smOutHits;
  logic        smOutMatch;
  logic [1:0]  smMatchCount;

  int total;
  int bad;
  int rxCount;

  logic [8:0] txWords[$];
  logic [6:0] expQ[$];

  popcount_match_pipe #(.WIDTH(9), .NTARGETS(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ids(in_ids),
    .out_valid(out_valid), .out_ready(out_ready), .out_ones(out_ones),
    .out_hits(out_hits), .out_match(out_match),
    .clr_count(clr_count), .match_count(match_count)
  );

  popcount_match_pipe #(.WIDTH(9), .NTARGETS(2), .CNT_W(2)) dutSmall (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(smInReady), .in_data(in_data), .in_ids(in_ids),
    .out_valid(smOutValid), .out_ready(out_ready), .out_ones(smOutOnes),
    .out_hits(smOutHits), .out_match(smOutMatch),
    .clr_count(clr_count), .match_count(smMatchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison. A failure is counted and reported with its tag.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {ones[3:0], hits[1:0], match}.
  function automatic logic [6:0] expOf(input logic [8:0] d, input logic [63:0] ids);
    logic [31:0] ones;
    logic [1:0]  h;
    ones = 32'($countones(d));
    h[0] = (ones == (ids[31:0]  % 32'd10));
    h[1] = (ones == (ids[63:32] % 32'd10));
    return {ones[3:0], h, |h};
  endfunction

  function automatic logic [31:0] obsVec();
    return {25'd0, out_ones, out_hits, out_match};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams txWords through the DUT and scores each result in order.
  // out_ready is held low for the first stallCycles cycles. While it is low,
  // the presented result must hold steady.
  task automatic applyStimulus(input int stallCycles, input int maxCycles, input string tag);
    int         sent;
    logic       accept;
    logic [6:0] acceptExp;
    logic [31:0] snap;
    logic       haveSnap;
    sent      = 0;
    accept    = 1'b0;
    acceptExp = '0;
    snap      = '0;
    haveSnap  = 1'b0;
    rxCount   = 0;
    expQ.delete();
    for (int cyc = 0; cyc < maxCycles; cyc++) begin
      tick();
      if (accept) expQ.push_back(acceptExp);
      out_ready = (cyc >= stallCycles);
      #1;
      if (out_valid && out_ready) begin
        if (expQ.size() > 0) begin
          checkOutput({tag, "_result"}, obsVec(), {25'd0, expQ.pop_front()});
        end else begin
          checkOutput({tag, "_unexpectedResult"}, 32'd1, 32'd0);
        end
        rxCount++;
      end else if (out_valid) begin
        if (!haveSnap) begin
          snap     = obsVec();
          haveSnap = 1'b1;
        end else begin
          checkOutput({tag, "_stallHold"}, obsVec(), snap);
        end
      end
      if (sent == txWords.size() && expQ.size() == 0 && !out_valid) break;
      if (sent < txWords.size()) begin
        in_data  = txWords[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stallCycles > 0 && cyc == 2) checkOutput({tag, "_inReadyLow"}, 32'(in_ready), 32'd0);
      accept = in_valid && in_ready;
      if (accept) begin
        acceptExp = expOf(in_data, in_ids);
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput({tag, "_rxCount"}, 32'(rxCount), 32'(txWords.size()));
  endtask

  task automatic clearCounts();
    tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ids    = IDS_A;
    out_ready = 1'b1;
    clr_count = 1'b0;

    // Reset state
    #2;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutputs", obsVec(), 32'd0);
    checkOutput("rstCount", 32'(match_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rstInReady", 32'(in_ready), 32'd1);

    // Latency: all-zero word against digits {3,0}
    tick();
    in_ids   = IDS_A;
    in_data  = 9'b000000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("latS1NotOut", 32'(out_valid), 32'd0);
    tick();
    checkOutput("latOutValid", 32'(out_valid), 32'd1);
    checkOutput("latResult", obsVec(), {25'd0, 4'd0, 2'b01, 1'b1});
    tick();
    checkOutput("latConsumed", 32'(out_valid), 32'd0);
    checkOutput("latCount", 32'(match_count), 32'd1);

    // Full sweep of every 9-bit word at one word per cycle
    clearCounts();
    txWords.delete();
    for (int d = 0; d < 512; d++) txWords.push_back(9'(d));
    applyStimulus(0, 700, "sweep");
    checkOutput("sweepCount", 32'(match_count), 32'd85);
    checkOutput("sweepSmallSat", 32'(smMatchCount), 32'd3);

    // Back-pressure with three back-to-back words
    txWords.delete();
    txWords.push_back(9'h007);
    txWords.push_back(9'h001);
    txWords.push_back(9'h000);
    applyStimulus(5, 40, "stall");

    // IDs change right after the handshake; the word keeps the old digits
    tick();
    in_ids   = IDS_A;
    in_data  = 9'h007;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_ids   = IDS_B;
    tick();
    checkOutput("idChgValid", 32'(out_valid), 32'd1);
    checkOutput("idChgResult", obsVec(), {25'd0, 4'd3, 2'b10, 1'b1});
    tick();
    in_ids = IDS_A;

    // Saturation of the 2-bit counter
    clearCounts();
    for (int k = 1; k <= 5; k++) begin
      txWords.delete();
      txWords.push_back(9'h000);
      applyStimulus(0, 20, "satWord");
      checkOutput("satSmallCount", 32'(smMatchCount), (k < 3) ? 32'(k) : 32'd3);
      checkOutput("satMainCount", 32'(match_count), 32'(k));
    end

    // Clear in the same cycle as a matching output handshake
    tick();
    in_data  = 9'h000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("clrPreValid", 32'(out_valid), 32'd1);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    checkOutput("clrWinsMain", 32'(match_count), 32'd0);
    checkOutput("clrWinsSmall", 32'(smMatchCount), 32'd0);

    // Reset with two words in flight
    txWords.delete();
    txWords.push_back(9'h000);
    applyStimulus(0, 20, "preRst");
    checkOutput("preRstCount", 32'(match_count), 32'd1);
    tick();
    out_ready = 1'b0;
    in_data   = 9'h000;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    checkOutput("midRstFull", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstCount", 32'(match_count), 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("midRstNoResult", 32'(out_valid), 32'd0);
    end
    checkOutput("midRstCountAfter", 32'(match_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
